// File: rtl/present_pkg.sv
// Shared PRESENT datapath types: state width, nibble width and the
// serial substitution-layer FSM encoding.
package present_pkg;

   localparam int STATE_W  = 64;
   localparam int NIBBLE_W = 4;

   typedef logic [STATE_W-1:0] state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } slayer_fsm_t;

endpackage

// File: rtl/sbox.sv
// PRESENT 4-bit S-box, purely combinational.
module sbox (
   input  logic [3:0] data_i,
   output logic [3:0] data_o
);

   always_comb begin
      data_o = 4'h0;
      unique case (data_i)
         4'h0: data_o = 4'hC;
         4'h1: data_o = 4'h5;
         4'h2: data_o = 4'h6;
         4'h3: data_o = 4'hB;
         4'h4: data_o = 4'h9;
         4'h5: data_o = 4'h0;
         4'h6: data_o = 4'hA;
         4'h7: data_o = 4'hD;
         4'h8: data_o = 4'h3;
         4'h9: data_o = 4'hE;
         4'hA: data_o = 4'hF;
         4'hB: data_o = 4'h8;
         4'hC: data_o = 4'h4;
         4'hD: data_o = 4'h7;
         4'hE: data_o = 4'h1;
         4'hF: data_o = 4'h2;
         default: data_o = 4'h0;
      endcase
   end

endmodule

// File: rtl/present_slayer_serial.sv
// Nibble-serial PRESENT substitution layer: one shared S-box, state rotated
// right by one nibble per clock, valid/ready on both sides.
module present_slayer_serial
   import present_pkg::*;
#(
   parameter int NIBBLES = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [NIBBLE_W*NIBBLES-1:0]   data_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [NIBBLE_W*NIBBLES-1:0]   data_o
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

   slayer_fsm_t          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [W-1:0]         data_q, data_d;
   logic [NIBBLE_W-1:0]  sbox_out;

   sbox u_sbox (
      .data_i (data_q[NIBBLE_W-1:0]),
      .data_o (sbox_out)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      ready_o = 1'b0;
      valid_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               data_d  = data_i;
               cnt_d   = '0;
               state_d = SUB;
            end
         end
         SUB: begin
            // After NIBBLES rotations every nibble is back in its original slot.
            data_d = {sbox_out, data_q[W-1:NIBBLE_W]};
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            valid_o = 1'b1;
            if (ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   assign data_o = data_q;

endmodule
